// File: rtl/ladybird_inst_seq_if.sv
// Command and instruction streams of the RV32I instruction sequencer.
// The sequencer is the slave: it consumes commands and produces instructions.
interface ladybird_inst_seq_if #(
  parameter int XLEN = 32
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [4:0]      cmd_rd;
  logic [XLEN-1:0] cmd_addr;
  logic [XLEN-1:0] cmd_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic            inst_last;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_addr, cmd_data, inst_ready,
    output cmd_ready, inst_valid, inst, inst_last
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_addr, cmd_data, inst_ready,
    input  cmd_ready, inst_valid, inst, inst_last
  );
endinterface

// File: rtl/ladybird_inst_seq.sv
// Command-driven RV32I instruction sequencer: a small command FIFO feeds a
// two-state expander that turns LI/LW/SW/JUMP into 1..4 encoded instructions.
module ladybird_inst_seq #(
  parameter int         XLEN      = 32,
  parameter int         CMD_DEPTH = 4,
  parameter logic [4:0] TMP_A     = 5'd31,
  parameter logic [4:0] TMP_D     = 5'd30,
  parameter int         CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rstn,
  ladybird_inst_seq_if.slave bus,
  output logic               busy,
  output logic [CNT_W-1:0]   inst_count
);

  localparam int AW = $clog2(CMD_DEPTH);

  localparam logic [1:0] OP_LI   = 2'd0;
  localparam logic [1:0] OP_LW   = 2'd1;
  localparam logic [1:0] OP_SW   = 2'd2;
  localparam logic [1:0] OP_JUMP = 2'd3;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  typedef enum logic {IDLE, EMIT} state_t;

  typedef struct packed {
    logic [1:0]      op;
    logic [4:0]      rd;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } cmd_t;

  // I-type encoder (ADDI, LW, JALR)
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, OPC_LUI};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
  endfunction

  // ---------------------------------------------------------------- FIFO
  cmd_t        fifo_q [CMD_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, push, pop;
  cmd_t        cmd_in, head;

  assign empty         = (wr_ptr_q == rd_ptr_q);
  assign full          = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Readiness deliberately ignores a same-cycle pop.
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;
  assign cmd_in        = {bus.cmd_op, bus.cmd_rd, bus.cmd_addr, bus.cmd_data};
  assign head          = fifo_q[rd_ptr_q[AW-1:0]];

  // FIFO storage write; contents need no reset since pointers gate them
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= cmd_in;
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ------------------------------------------------- list generator
  // Split of v: lo = v[11:0] (sign-extended by the ISA), hi rounds up when
  // lo is negative so that LUI hi; ADDI lo reconstructs v (mod 2^20).
  logic [11:0]      a_lo, d_lo;
  logic [19:0]      a_hi, d_hi;
  logic             d_small;
  logic [4:0]       lw_base;
  logic [3:0][31:0] gen_list;
  logic [1:0]       gen_last;

  assign a_lo    = head.addr[11:0];
  assign a_hi    = head.addr[31:12] + {19'd0, head.addr[11]};
  assign d_lo    = head.data[11:0];
  assign d_hi    = head.data[31:12] + {19'd0, head.data[11]};
  assign d_small = (&head.data[31:11]) || !(|head.data[31:11]);
  assign lw_base = (head.rd == 5'd0) ? TMP_A : head.rd;

  // Expand the command at the FIFO head into its instruction list
  always_comb begin
    gen_list = '0;
    gen_last = 2'd0;
    case (head.op)
      OP_LI: begin
        if (d_small) begin
          gen_list[0] = enc_i(d_lo, 5'd0, 3'b000, head.rd, OPC_OPIMM);
        end else begin
          gen_list[0] = enc_lui(d_hi, head.rd);
          if (d_lo != 12'd0) begin
            gen_list[1] = enc_i(d_lo, head.rd, 3'b000, head.rd, OPC_OPIMM);
            gen_last    = 2'd1;
          end
        end
      end
      OP_LW: begin
        gen_list[0] = enc_lui(a_hi, lw_base);
        gen_list[1] = enc_i(a_lo, lw_base, 3'b010, head.rd, OPC_LOAD);
        gen_last    = 2'd1;
      end
      OP_SW: begin
        gen_list[0] = enc_lui(a_hi, TMP_A);
        if (d_small) begin
          gen_list[1] = enc_i(d_lo, 5'd0, 3'b000, TMP_D, OPC_OPIMM);
          gen_list[2] = enc_sw(a_lo, TMP_D, TMP_A);
          gen_last    = 2'd2;
        end else if (d_lo != 12'd0) begin
          gen_list[1] = enc_lui(d_hi, TMP_D);
          gen_list[2] = enc_i(d_lo, TMP_D, 3'b000, TMP_D, OPC_OPIMM);
          gen_list[3] = enc_sw(a_lo, TMP_D, TMP_A);
          gen_last    = 2'd3;
        end else begin
          gen_list[1] = enc_lui(d_hi, TMP_D);
          gen_list[2] = enc_sw(a_lo, TMP_D, TMP_A);
          gen_last    = 2'd2;
        end
      end
      default: begin // OP_JUMP; addr[1:0] passes through unchecked
        gen_list[0] = enc_lui(a_hi, TMP_A);
        gen_list[1] = enc_i(a_lo, TMP_A, 3'b000, 5'd0, OPC_JALR);
        gen_last    = 2'd1;
      end
    endcase
  end

  // ------------------------------------------------------------- FSM
  state_t           state_q, state_d;
  logic             arm_q;
  logic [1:0]       step_q, step_d, last_idx_q, last_idx_d, step_inc;
  logic [3:0][31:0] list_q, list_d;
  logic [31:0]      inst_q, inst_d;
  logic             last_q, last_d, valid_q, valid_d, load;
  logic [CNT_W-1:0] cnt_q;

  assign step_inc = step_q + 2'd1;

  // Next-state: start a command from IDLE (after one settle cycle, arm_q),
  // step through the list on each accept, chain the next command with no bubble
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    last_idx_d = last_idx_q;
    list_d     = list_q;
    inst_d     = inst_q;
    last_d     = last_q;
    valid_d    = valid_q;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && arm_q) load = 1'b1;
      end
      default: begin
        if (bus.inst_ready) begin
          if (last_q) begin
            if (!empty) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
              inst_d  = '0;
              last_d  = 1'b0;
              step_d  = 2'd0;
            end
          end else begin
            step_d = step_inc;
            inst_d = list_q[step_inc];
            last_d = (step_inc == last_idx_q);
          end
        end
      end
    endcase
    if (load) begin
      state_d    = EMIT;
      list_d     = gen_list;
      last_idx_d = gen_last;
      step_d     = 2'd0;
      inst_d     = gen_list[0];
      last_d     = (gen_last == 2'd0);
      valid_d    = 1'b1;
    end
  end

  assign pop = load;

  // FSM and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      arm_q      <= 1'b0;
      step_q     <= 2'd0;
      last_idx_q <= 2'd0;
      list_q     <= '0;
      inst_q     <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_q      <= !empty;
      step_q     <= step_d;
      last_idx_q <= last_idx_d;
      list_q     <= list_d;
      inst_q     <= inst_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
    end
  end

  // Accepted-instruction counter, wraps freely
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else if (valid_q && bus.inst_ready) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.inst_valid = valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_last  = last_q;
  assign busy           = !empty || (state_q == EMIT);
  assign inst_count     = cnt_q;

endmodule

// File: tb/tb_ladybird_inst_seq.sv
// Directed testbench for ladybird_inst_seq with hand-computed encodings.
module tb_ladybird_inst_seq;
  logic        clk = 1'b0;
  logic        rstn;
  logic        busy;
  logic [15:0] inst_count;
  int          checks   = 0;
  int          failures = 0;
  int          exp_cnt  = 0;
  logic        acc;
  int          seen;

  localparam logic [1:0] OP_LI = 2'd0, OP_LW = 2'd1, OP_SW = 2'd2, OP_JUMP = 2'd3;

  ladybird_inst_seq_if bus ();

  ladybird_inst_seq dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .busy      (busy),
    .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h want=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one command for one clock edge.
  task automatic push(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] addr,
                      input logic [31:0] data, output logic accepted);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    accepted      = bus.cmd_ready;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    $display("cmd op=%0d rd=%0d addr=0x%08h data=0x%08h accepted=%0d", op, rd, addr, data, accepted);
  endtask

  // Waits (bounded) for an instruction, checks it, then moves to the next negedge.
  task automatic expect_inst(input string tag, input logic [31:0] ei, input logic el,
                             input int ew);
    int w = 0;
    while (!bus.inst_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, ".valid"}, 32'(bus.inst_valid), 32'd1);
    chk({tag, ".inst"}, bus.inst, ei);
    chk({tag, ".last"}, 32'(bus.inst_last), 32'(el));
    if (ew >= 0) chk({tag, ".wait"}, 32'(w), 32'(ew));
    $display("inst %s = 0x%08h last=%0d wait=%0d", tag, bus.inst, bus.inst_last, w);
    if (bus.inst_valid && bus.inst_ready) exp_cnt++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'd0;
    bus.cmd_rd     = 5'd0;
    bus.cmd_addr   = '0;
    bus.cmd_data   = '0;
    bus.inst_ready = 1'b1;
    rstn           = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.valid", 32'(bus.inst_valid), 32'd0);
    chk("rst.inst", bus.inst, 32'd0);
    chk("rst.last", 32'(bus.inst_last), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.count", 32'(inst_count), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // LI small: single ADDI, two-cycle start latency
    push(OP_LI, 5'd5, 32'h0, 32'h0000_0123, acc);
    expect_inst("li_small", 32'h1230_0293, 1'b1, 2);
    chk("li_small.count", 32'(inst_count), 32'(exp_cnt));
    chk("li_small.idle", 32'(bus.inst_valid), 32'd0);
    chk("li_small.busy", 32'(busy), 32'd0);

    // LI needing LUI + ADDI with rounded-up hi
    push(OP_LI, 5'd5, 32'h0, 32'h1234_5FFF, acc);
    expect_inst("li_big0", 32'h1234_62B7, 1'b0, 2);
    expect_inst("li_big1", 32'hFFF2_8293, 1'b1, 0);

    // LI with lo==0: ADDI suppressed
    push(OP_LI, 5'd5, 32'h0, 32'h1234_5000, acc);
    expect_inst("li_lui", 32'h1234_52B7, 1'b1, 2);

    // LI at the negative edge of the short range
    push(OP_LI, 5'd5, 32'h0, 32'hFFFF_F800, acc);
    expect_inst("li_min", 32'h8000_0293, 1'b1, 2);

    // JUMP
    push(OP_JUMP, 5'd0, 32'h8000_0004, 32'h0, acc);
    expect_inst("jump0", 32'h8000_0FB7, 1'b0, 2);
    expect_inst("jump1", 32'h004F_8067, 1'b1, 0);

    // LW x7
    push(OP_LW, 5'd7, 32'h1234_5678, 32'h0, acc);
    expect_inst("lw0", 32'h1234_53B7, 1'b0, 2);
    expect_inst("lw1", 32'h6783_A383, 1'b1, 0);

    // LW x0 with hi wrap: base becomes TMP_A, hi = 0
    push(OP_LW, 5'd0, 32'hFFFF_F800, 32'h0, acc);
    expect_inst("lwx0_0", 32'h0000_0FB7, 1'b0, 2);
    expect_inst("lwx0_1", 32'h800F_A003, 1'b1, 0);
    chk("count.mid", 32'(inst_count), 32'(exp_cnt));

    // SW with 5-cycle stall on the data instruction
    push(OP_SW, 5'd0, 32'h0000_1004, 32'h0000_0005, acc);
    expect_inst("sw0", 32'h0000_1FB7, 1'b0, 2);
    bus.inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("sw_stall.valid", 32'(bus.inst_valid), 32'd1);
      chk("sw_stall.inst", bus.inst, 32'h0050_0F13);
      @(negedge clk);
    end
    bus.inst_ready = 1'b1;
    expect_inst("sw1", 32'h0050_0F13, 1'b0, 0);
    expect_inst("sw2", 32'h01EF_A223, 1'b1, 0);
    chk("count.sw", 32'(inst_count), 32'(exp_cnt));

    // Fill the FIFO behind a stalled command; fifth push must be refused
    bus.inst_ready = 1'b0;
    push(OP_LI, 5'd5, 32'h0, 32'h1234_5FFF, acc);
    for (int w = 0; w < 20 && !bus.inst_valid; w++) @(negedge clk);
    push(OP_LI, 5'd1, 32'h0, 32'd1, acc);
    chk("fill.acc1", 32'(acc), 32'd1);
    push(OP_LI, 5'd2, 32'h0, 32'd2, acc);
    chk("fill.acc2", 32'(acc), 32'd1);
    push(OP_LI, 5'd3, 32'h0, 32'd3, acc);
    chk("fill.acc3", 32'(acc), 32'd1);
    push(OP_JUMP, 5'd0, 32'h8000_0004, 32'h0, acc);
    chk("fill.acc4", 32'(acc), 32'd1);
    push(OP_LI, 5'd4, 32'h0, 32'd4, acc);
    chk("fill.acc5", 32'(acc), 32'd0);
    chk("fill.busy", 32'(busy), 32'd1);
    bus.inst_ready = 1'b1;
    expect_inst("q_pre0", 32'h1234_62B7, 1'b0, 0);
    expect_inst("q_pre1", 32'hFFF2_8293, 1'b1, 0);
    expect_inst("q_li1", 32'h0010_0093, 1'b1, 0);
    expect_inst("q_li2", 32'h0020_0113, 1'b1, 0);
    expect_inst("q_li3", 32'h0030_0193, 1'b1, 0);
    expect_inst("q_j0", 32'h8000_0FB7, 1'b0, 0);
    expect_inst("q_j1", 32'h004F_8067, 1'b1, 0);
    chk("q.idle", 32'(bus.inst_valid), 32'd0);
    chk("q.busy", 32'(busy), 32'd0);
    chk("q.count", 32'(inst_count), 32'(exp_cnt));

    // Reset during step 1 of SW with three commands queued
    bus.inst_ready = 1'b0;
    push(OP_SW, 5'd0, 32'h0000_1004, 32'h0000_0005, acc);
    for (int w = 0; w < 20 && !bus.inst_valid; w++) @(negedge clk);
    push(OP_LI, 5'd1, 32'h0, 32'd1, acc);
    push(OP_LI, 5'd2, 32'h0, 32'd2, acc);
    push(OP_LI, 5'd3, 32'h0, 32'd3, acc);
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    chk("mid.step1", bus.inst, 32'h0050_0F13);
    rstn = 1'b0;
    #1;
    chk("mrst.valid", 32'(bus.inst_valid), 32'd0);
    chk("mrst.inst", bus.inst, 32'd0);
    chk("mrst.last", 32'(bus.inst_last), 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.count", 32'(inst_count), 32'd0);
    @(negedge clk);
    rstn           = 1'b1;
    bus.inst_ready = 1'b1;
    seen           = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.inst_valid) seen++;
    end
    chk("mrst.no_inst", 32'(seen), 32'd0);
    chk("mrst.busy_after", 32'(busy), 32'd0);
    chk("mrst.count_after", 32'(inst_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ladybird_inst_seq.md
Name: ladybird_inst_seq

Overview:
- Command-driven RISC-V RV32I instruction sequencer. Expands high-level commands (load immediate, load word, store word, jump) into a stream of encoded instructions.
- Feeds a core's I_BUS injection path for boot, debug and self-test.
- Generalises the single-instruction constructors into a buffered, back-pressured, multi-instruction generator. Sequence length depends on the operand values.

Parameters:
- XLEN, 32, data/address width; only 32 is legal.
- CMD_DEPTH, 4, command FIFO entries; power of two, ≥2.
- TMP_A, 5'd31, scratch register for address materialisation.
- TMP_D, 5'd30, scratch register for store data; must differ from TMP_A.
- CNT_W, 16, width of the emitted-instruction counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full.
- cmd_op  in  2  command: 0=LI, 1=LW, 2=SW, 3=JUMP.
- cmd_rd  in  5  destination register (LI, LW).
- cmd_addr  in  32  target address (LW, SW, JUMP).
- cmd_data  in  32  immediate (LI) or store data (SW).
- inst_valid  out  1  instruction available.
- inst_ready  in  1  consumer accepts.
- inst  out  32  encoded instruction.
- inst_last  out  1  current instruction is the final one of its command.
- busy  out  1  FIFO non-empty or sequence in progress.
- inst_count  out  CNT_W  count of accepted instructions; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rstn=0): FIFO empty; state IDLE; inst_valid=0, inst=0, inst_last=0, busy=0, inst_count=0. cmd_ready=1 as soon as rstn=1.
  - Reset mid-sequence discards the remaining instructions and all queued commands.
- FIFO:
  - Push on cmd_valid&&cmd_ready.
  - cmd_ready = !full; it ignores same-cycle pops, so a full FIFO is never pushed even when a pop occurs that cycle.
- FSM:
  - States: IDLE, EMIT.
  - IDLE with FIFO non-empty: pop, latch the command, compute its instruction list, go to EMIT with step=0.
  - EMIT: inst_valid=1, inst=list[step].
    - On inst_ready: step+1.
    - After the last step: pop the next command directly if FIFO non-empty (EMIT continues with no bubble), else go to IDLE.
  - Latency: a command pushed into an empty FIFO while IDLE gives inst_valid 2 cycles after the push edge.
- Handshake:
  - inst and inst_last are registered and held stable while inst_valid&&!inst_ready.
  - inst_valid never drops without a transfer.
  - inst_count increments on each inst_valid&&inst_ready.
- Split of a 32-bit value v:
  - lo = v[11:0], sign-extended.
  - hi = v[31:12] + v[11], mod 2^20, so LUI hi followed by ADDI lo yields v. Wrap case: v=0xFFFFF800 gives hi=0x00000.
- Instruction lists (standard RV32I encodings):
  - LI, v in [-2048, 2047]: ADDI rd,x0,lo.
  - LI, otherwise: LUI rd,hi, then ADDI rd,rd,lo only if lo≠0.
  - LI with rd=x0 still emits the ADDI/LUI; it is architecturally a NOP.
  - LW: LUI rd,hi(addr); LW rd,lo(addr)(rd). If rd=x0, TMP_A replaces rd as base.
  - SW: LUI TMP_A,hi(addr); the LI sequence for data into TMP_D (1–2 instructions); SW TMP_D,lo(addr)(TMP_A).
  - JUMP: LUI TMP_A,hi(addr); JALR x0,TMP_A,lo(addr). addr[1:0] is passed through unchecked.
- inst_last=1 only on the final list entry.
- busy = FIFO non-empty || state==EMIT.
- Counter: CNT_W bits, no saturation.

Test Plan:
- LI x5, 0x00000123 → single inst 0x12300293, inst_last=1, inst_count=1.
- LI x5, 0x12345FFF → 0x123462B7 then 0xFFF28293; inst_last only on the second instruction.
- LI x5, 0x12345000 → single 0x123452B7 with inst_last=1 (ADDI suppressed).
- JUMP 0x80000004 (TMP_A=31) → 0x80000FB7 then 0x004F8067.
- Back-pressure: hold inst_ready=0 for 5 cycles mid-SW → inst constant and inst_valid=1 throughout. Push CMD_DEPTH+1 commands back-to-back → cmd_ready=0 on the fifth; all queued sequences emitted with no idle cycle between commands.
- Assert rstn=0 during step 1 of SW with 3 commands queued → outputs zero at once; after release, busy=0 and no further instructions are emitted.
